// File: rtl/dff_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dff_chk_pkg
// Purpose  : Shared types and constants for the DFF response checker.
//            Provides the checker state encoding, the maximum supported
//            pipeline latency, the fill counter width and a {valid, data}
//            sample record at the default data width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dff_chk_pkg;

    localparam int MAX_LATENCY   = 8;
    localparam int FILL_CNT_W    = 4;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } chk_state_e;

    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] data;
    } chk_sample_t;

endpackage
`default_nettype wire

// File: rtl/dff_chk_delay.sv
`default_nettype none
// ============================================================================
// Module   : dff_chk_delay
// Purpose  : LATENCY-deep shift register of {valid, data} samples used to
//            line up stimulus with the DUT response.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            shift           - advance the line by one stage this edge
//            flush           - clear every valid bit (wins over shift)
//            in_valid/in_data- sample entering stage 0
//            out_valid/out_data - contents of the last stage
// Revision : 1.0 - initial release
// ============================================================================
module dff_chk_delay
    import dff_chk_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0]            r_valid;
    logic [LATENCY-1:0][WIDTH-1:0] r_data;
    logic [LATENCY-1:0]            w_valid_feed;
    logic [LATENCY-1:0][WIDTH-1:0] w_data_feed;

    // Stage i is fed from stage i-1; stage 0 from the input.
    assign w_valid_feed[0] = in_valid;
    assign w_data_feed[0]  = in_data;

    genvar gi;
    for (gi = 1; gi < LATENCY; gi++) begin : g_chain
        assign w_valid_feed[gi] = r_valid[gi-1];
        assign w_data_feed[gi]  = r_data[gi-1];
    end

    // A flush only drops the valid bits; stale data is harmless once invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (shift) begin
            r_valid <= w_valid_feed;
            r_data  <= w_data_feed;
        end
    end

    assign out_valid = r_valid[LATENCY-1];
    assign out_data  = r_data[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/dff_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : dff_resp_checker
// Purpose  : Response checker for a DFF-style DUT. Delays the stimulus by
//            LATENCY samples and compares it with the DUT response, keeping
//            saturating match/mismatch counts, a sticky error flag and a
//            halt state after MAX_ERR mismatches.
//            Optional macro DFF_CHK_FIRST_ERR_EN builds capture registers
//            for the first mismatch; otherwise first_* are tied to 0.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            en                  - checking enable (level)
//            clear               - synchronous clear back to IDLE
//            in_valid, inp       - stimulus sample and its qualifier
//            outp                - DUT response
//            match_cnt           - saturating count of matching compares
//            mismatch_cnt        - saturating count of mismatching compares
//            err                 - sticky mismatch flag
//            halted              - high while in HALT
//            state               - IDLE=0, FILL=1, CHECK=2, HALT=3
//            first_exp/got/idx   - first mismatch record (optional)
// Revision : 1.0 - initial release
// ============================================================================
module dff_resp_checker
    import dff_chk_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16,
    parameter int MAX_ERR = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] inp,
    input  logic [WIDTH-1:0] outp,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             err,
    output logic             halted,
    output logic [1:0]       state,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got,
    output logic [CNT_W-1:0] first_idx
);

    // Depth is clamped into the supported range so an out-of-range
    // LATENCY cannot build a zero-length or oversized line.
    localparam int c_DEPTH = (LATENCY < 1) ? 1 :
                             ((LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY);
    localparam logic [FILL_CNT_W-1:0] c_FILL_LAST = FILL_CNT_W'(c_DEPTH - 1);
    localparam logic [FILL_CNT_W-1:0] c_FILL_ONE  = FILL_CNT_W'(1);
    localparam logic [CNT_W-1:0]      c_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]      c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      c_MAX_ERR   = CNT_W'(MAX_ERR);

    chk_state_e            r_state;
    chk_state_e            w_next_state;
    logic [FILL_CNT_W-1:0] r_fill_cnt;
    logic                  r_halted;
    logic [CNT_W-1:0]      r_match;
    logic [CNT_W-1:0]      r_mis;
    logic                  r_err;

    logic                  w_active;
    logic                  w_flush;
    logic                  w_last_valid;
    logic [WIDTH-1:0]      w_last_data;
    logic                  w_cmp;
    logic                  w_hit;
    logic                  w_miss;
    logic [CNT_W-1:0]      w_mis_next;
    logic                  w_halt_hit;

    // ------------------------------------------------------------------
    // Stimulus delay line
    // ------------------------------------------------------------------
    assign w_active = (r_state == FILL) || (r_state == CHECK);

    // Dropping en while active invalidates the line so stale samples are
    // never compared after re-enable. A halting mismatch keeps the line.
    assign w_flush = clear || (w_active && !en && !w_halt_hit);

    dff_chk_delay #(
        .WIDTH   (WIDTH),
        .LATENCY (c_DEPTH)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift     (w_active),
        .flush     (w_flush),
        .in_valid  (in_valid & en),
        .in_data   (inp),
        .out_valid (w_last_valid),
        .out_data  (w_last_data)
    );

    // ------------------------------------------------------------------
    // Compare
    // ------------------------------------------------------------------
    assign w_cmp      = (r_state == CHECK) && w_last_valid && !clear;
    assign w_hit      = w_cmp && (w_last_data == outp);
    assign w_miss     = w_cmp && (w_last_data != outp);
    assign w_mis_next = (r_mis == c_CNT_MAX) ? r_mis : (r_mis + c_CNT_ONE);
    assign w_halt_hit = w_miss && (w_mis_next == c_MAX_ERR);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fill_cnt <= '0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_fill_cnt <= ((r_state == FILL) && (w_next_state == FILL)) ?
                          (r_fill_cnt + c_FILL_ONE) : '0;
            r_halted   <= (w_next_state == HALT);
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) w_next_state = FILL;
                end
                FILL: begin
                    if (!en)                           w_next_state = IDLE;
                    else if (r_fill_cnt == c_FILL_LAST) w_next_state = CHECK;
                end
                CHECK: begin
                    // Reaching the error limit wins over a simultaneous en drop.
                    if (w_halt_hit) w_next_state = HALT;
                    else if (!en)   w_next_state = IDLE;
                end
                HALT: begin
                    w_next_state = HALT;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counters and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match <= '0;
            r_mis   <= '0;
            r_err   <= 1'b0;
        end else if (clear) begin
            r_match <= '0;
            r_mis   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_hit && (r_match != c_CNT_MAX)) begin
                r_match <= r_match + c_CNT_ONE;
            end
            if (w_miss) begin
                r_mis <= w_mis_next;
                r_err <= 1'b1;
            end
        end
    end

    assign match_cnt    = r_match;
    assign mismatch_cnt = r_mis;
    assign err          = r_err;
    assign halted       = r_halted;
    assign state        = r_state;

    // ------------------------------------------------------------------
    // First-mismatch record
    // ------------------------------------------------------------------
`ifdef DFF_CHK_FIRST_ERR_EN
    logic [WIDTH-1:0] r_first_exp;
    logic [WIDTH-1:0] r_first_got;
    logic [CNT_W-1:0] r_first_idx;

    // err still low means no mismatch has been recorded since reset/clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first_exp <= '0;
            r_first_got <= '0;
            r_first_idx <= '0;
        end else if (clear) begin
            r_first_exp <= '0;
            r_first_got <= '0;
            r_first_idx <= '0;
        end else if (w_miss && !r_err) begin
            r_first_exp <= w_last_data;
            r_first_got <= outp;
            r_first_idx <= r_match + r_mis;
        end
    end

    assign first_exp = r_first_exp;
    assign first_got = r_first_got;
    assign first_idx = r_first_idx;
`else
    assign first_exp = '0;
    assign first_got = '0;
    assign first_idx = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_resp_checker
// Purpose  : Directed self-checking bench for dff_resp_checker with a
//            behavioural 8-bit DFF as the checked DUT. The DFF output can be
//            corrupted to 0xFF or stuck at 0x00 to provoke mismatches.
//            First-mismatch expectations follow DFF_CHK_FIRST_ERR_EN.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_resp_checker;

    localparam int c_WIDTH = 8;
    localparam int c_CNT_W = 16;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               clear;
    logic               in_valid;
    logic [c_WIDTH-1:0] inp;
    logic [c_WIDTH-1:0] outp;
    logic [c_CNT_W-1:0] match_cnt;
    logic [c_CNT_W-1:0] mismatch_cnt;
    logic               err;
    logic               halted;
    logic [1:0]         state;
    logic [c_WIDTH-1:0] first_exp;
    logic [c_WIDTH-1:0] first_got;
    logic [c_CNT_W-1:0] first_idx;

    // Behavioural DUT: a plain DFF with fault injection on its output.
    logic [c_WIDTH-1:0] dff_q;
    logic               corrupt;
    logic               stuck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dff_q <= '0;
        else        dff_q <= inp;
    end

    assign outp = stuck ? 8'h00 : (corrupt ? 8'hFF : dff_q);

    int n_checks = 0;
    int n_fail   = 0;

    dff_resp_checker #(
        .WIDTH   (8),
        .LATENCY (1),
        .CNT_W   (16),
        .MAX_ERR (4)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .clear        (clear),
        .in_valid     (in_valid),
        .inp          (inp),
        .outp         (outp),
        .match_cnt    (match_cnt),
        .mismatch_cnt (mismatch_cnt),
        .err          (err),
        .halted       (halted),
        .state        (state),
        .first_exp    (first_exp),
        .first_got    (first_got),
        .first_idx    (first_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_first(input string tag, input logic [7:0] e, input logic [7:0] g,
                             input logic [15:0] i);
`ifdef DFF_CHK_FIRST_ERR_EN
        chk({tag, "_exp"}, 32'(first_exp), 32'(e));
        chk({tag, "_got"}, 32'(first_got), 32'(g));
        chk({tag, "_idx"}, 32'(first_idx), 32'(i));
`else
        chk({tag, "_exp"}, 32'(first_exp), 32'h0);
        chk({tag, "_got"}, 32'(first_got), 32'h0);
        chk({tag, "_idx"}, 32'(first_idx), 32'h0);
        if (e == 8'h00 && g == 8'h00 && i == 16'h0) begin end
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        inp      = '0;
        corrupt  = 1'b0;
        stuck    = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_state",    32'(state), 32'd0);
        chk("rst_match",    32'(match_cnt), 32'd0);
        chk("rst_mismatch", 32'(mismatch_cnt), 32'd0);
        chk("rst_err",      32'(err), 32'd0);
        chk("rst_halted",   32'(halted), 32'd0);
        chk_first("rst_first", 8'h00, 8'h00, 16'd0);

        // ---------------- clean DFF, 16 samples ----------------
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        chk("t1_fill", 32'(state), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            inp      = 8'(k);
            in_valid = 1'b1;
            step();
            if (k == 1) begin
                chk("t1_check_entry", 32'(state), 32'd2);
                chk("t1_no_cmp_in_fill", 32'(match_cnt), 32'd0);
            end
        end
        in_valid = 1'b0;
        step();
        chk("t1_match",    32'(match_cnt), 32'd16);
        chk("t1_mismatch", 32'(mismatch_cnt), 32'd0);
        chk("t1_err",      32'(err), 32'd0);
        chk("t1_state",    32'(state), 32'd2);

        // ---------------- single corrupted response ----------------
        clear = 1'b1;
        en    = 1'b0;
        step();
        chk("t2_clr_state", 32'(state), 32'd0);
        chk("t2_clr_match", 32'(match_cnt), 32'd0);
        clear = 1'b0;
        en    = 1'b1;
        step();
        for (int k = 1; k <= 16; k++) begin
            inp      = 8'(k);
            in_valid = 1'b1;
            corrupt  = (k == 6);
            step();
            if (k == 6) begin
                chk("t2_err_set", 32'(err), 32'd1);
                chk("t2_mis_one", 32'(mismatch_cnt), 32'd1);
            end
        end
        corrupt  = 1'b0;
        in_valid = 1'b0;
        step();
        chk("t2_match",    32'(match_cnt), 32'd15);
        chk("t2_mismatch", 32'(mismatch_cnt), 32'd1);
        chk("t2_err",      32'(err), 32'd1);
        chk("t2_state",    32'(state), 32'd2);
        chk_first("t2_first", 8'h05, 8'hFF, 16'd4);

        // ---------------- stuck-at-zero, halt after 4 ----------------
        clear = 1'b1;
        en    = 1'b0;
        step();
        chk("t3_clr_err", 32'(err), 32'd0);
        chk_first("t3_clr_first", 8'h00, 8'h00, 16'd0);
        clear = 1'b0;
        en    = 1'b1;
        step();
        stuck = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            inp      = 8'hA0 + 8'(k);
            in_valid = 1'b1;
            step();
            if (k == 4) begin
                chk("t3_mis3",     32'(mismatch_cnt), 32'd3);
                chk("t3_not_halt", 32'(halted), 32'd0);
            end
            if (k == 5) begin
                chk("t3_halted",   32'(halted), 32'd1);
                chk("t3_halt_st",  32'(state), 32'd3);
                chk("t3_mis4",     32'(mismatch_cnt), 32'd4);
            end
        end
        chk("t3_frozen_mis",   32'(mismatch_cnt), 32'd4);
        chk("t3_frozen_match", 32'(match_cnt), 32'd0);
        chk("t3_still_halt",   32'(halted), 32'd1);
        chk_first("t3_first", 8'hA1, 8'h00, 16'd0);

        // ---------------- clear + en together in HALT ----------------
        clear = 1'b1;
        en    = 1'b1;
        step();
        chk("t6_idle",     32'(state), 32'd0);
        chk("t6_mis0",     32'(mismatch_cnt), 32'd0);
        chk("t6_match0",   32'(match_cnt), 32'd0);
        chk("t6_err0",     32'(err), 32'd0);
        chk("t6_halted0",  32'(halted), 32'd0);
        clear = 1'b0;
        stuck = 1'b0;
        step();
        chk("t6_fill", 32'(state), 32'd1);

        // ---------------- every other sample valid ----------------
        for (int k = 0; k < 10; k++) begin
            inp      = 8'h30 + 8'(k);
            in_valid = (k % 2 == 0);
            step();
        end
        chk("t4_match",    32'(match_cnt), 32'd5);
        chk("t4_mismatch", 32'(mismatch_cnt), 32'd0);
        chk("t4_state",    32'(state), 32'd2);

        // ---------------- en dropped for 3 cycles mid-CHECK ----------------
        en       = 1'b0;
        in_valid = 1'b1;
        inp      = 8'h55;
        step();
        chk("t5_idle",  32'(state), 32'd0);
        chk("t5_keep1", 32'(match_cnt), 32'd5);
        step();
        step();
        chk("t5_idle3", 32'(state), 32'd0);
        chk("t5_keep3", 32'(match_cnt), 32'd5);
        en  = 1'b1;
        inp = 8'h61;
        step();
        chk("t5_fill",  32'(state), 32'd1);
        chk("t5_keep4", 32'(match_cnt), 32'd5);
        inp = 8'h62;
        step();
        chk("t5_check", 32'(state), 32'd2);
        chk("t5_keep5", 32'(match_cnt), 32'd5);
        chk("t5_nomis", 32'(mismatch_cnt), 32'd0);
        inp = 8'h63;
        step();
        chk("t5_resume", 32'(match_cnt), 32'd6);

        // ---------------- async reset mid-CHECK ----------------
        stuck = 1'b1;
        inp   = 8'h64;
        step();
        chk("t7_pre_err", 32'(err), 32'd1);
        chk("t7_pre_mis", 32'(mismatch_cnt), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_state", 32'(state), 32'd0);
        chk("t7_match", 32'(match_cnt), 32'd0);
        chk("t7_mis",   32'(mismatch_cnt), 32'd0);
        chk("t7_err",   32'(err), 32'd0);
        chk("t7_halt",  32'(halted), 32'd0);
        chk_first("t7_first", 8'h00, 8'h00, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
